coincidence_weight_updater: RTL and testbench

- Downstream consumer of the deterministic pulse-train generator. It takes one row of x pulses (M bits) and delta pulses (N bits) per accepted beat.
- Applies a coincidence update to an M x N array of signed conductance-equivalent weights: on each beat, every cell with x[i] & delta[j] moves by one dG step.
- Models the crossbar programming stage of the training datapath; the weight array is readable in parallel by the inference side.

---
 rtl/coincidence_weight_updater.sv | 147 ++++++++++++++
 tb/tb_coincidence_weight_updater.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/coincidence_weight_updater.sv
// Coincidence weight updater: applies +/-DG to every crossbar cell whose x and delta pulses coincide.
// Optional build macro COINC_STATS_EN adds the coinc_cnt coincidence counter output.
module coincidence_weight_updater #(
   parameter int M      = 2,
   parameter int N      = 2,
   parameter int BL     = 10,
   parameter int W_BITS = 10,
   parameter int DG     = 25,
   parameter int WMAX   = 255,
   parameter int WMIN   = -255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          dir,
   input  logic                          init_en,
   input  logic signed [W_BITS-1:0]      init_val,
   input  logic                          pulse_valid,
   output logic                          pulse_ready,
   input  logic [M-1:0]                  x_pulse,
   input  logic [N-1:0]                  d_pulse,
   input  logic                          pulse_last,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(BL+1)-1:0]       beat_cnt,
   output logic [M*N*W_BITS-1:0]         wt_flat
`ifdef COINC_STATS_EN
   ,
   output logic [$clog2(BL*M*N+1)-1:0]   coinc_cnt
`endif
);

   localparam int CNT_W = $clog2(BL+1);
   localparam logic [CNT_W-1:0] BL_C = CNT_W'(BL);
   localparam logic signed [W_BITS:0] DG_E   = (W_BITS+1)'(DG);
   localparam logic signed [W_BITS:0] WMAX_E = (W_BITS+1)'(WMAX);
   localparam logic signed [W_BITS:0] WMIN_E = (W_BITS+1)'(WMIN);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t state_q, state_d;
   logic   dir_q;
   logic   accept_p0;
   logic signed [W_BITS:0]   step_p0;
   logic signed [W_BITS-1:0] wt_p1 [M][N];

   function automatic logic signed [W_BITS-1:0] sat(input logic signed [W_BITS:0] v);
      if (v > WMAX_E)
         return WMAX_E[W_BITS-1:0];
      else if (v < WMIN_E)
         return WMIN_E[W_BITS-1:0];
      else
         return v[W_BITS-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept_p0 && (pulse_last || (beat_cnt + CNT_W'(1)) == BL_C))
                     state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pulse_ready = (state_q == RUN);
      busy        = (state_q != IDLE);
      done        = (state_q == FINISH);
   end

   // stage 0: beat acceptance and signed step selection
   assign accept_p0 = pulse_valid & pulse_ready;
   assign step_p0   = dir_q ? -DG_E : DG_E;

   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q    <= 1'b0;
         beat_cnt <= '0;
      end else if (state_q == IDLE && start) begin
         dir_q    <= dir;
         beat_cnt <= '0;
      end else if (accept_p0) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

   // stage 1: registered weight array, saturated update in W_BITS+1 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
               wt_p1[i][j] <= '0;
      end else if (state_q == IDLE && init_en) begin
         for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
               wt_p1[i][j] <= sat($signed({init_val[W_BITS-1], init_val}));
      end else if (accept_p0) begin
         for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
               if (x_pulse[i] & d_pulse[j])
                  wt_p1[i][j] <= sat($signed({wt_p1[i][j][W_BITS-1], wt_p1[i][j]}) + step_p0);
      end
   end

   always_comb begin
      wt_flat = '0;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            wt_flat[(i*N+j)*W_BITS +: W_BITS] = wt_p1[i][j];
   end

`ifdef COINC_STATS_EN
   localparam int CC_W = $clog2(BL*M*N+1);

   function automatic logic [CC_W-1:0] popcnt_x(input logic [M-1:0] v);
      logic [CC_W-1:0] c;
      c = '0;
      for (int k = 0; k < M; k++) c = c + CC_W'(v[k]);
      return c;
   endfunction

   function automatic logic [CC_W-1:0] popcnt_d(input logic [N-1:0] v);
      logic [CC_W-1:0] c;
      c = '0;
      for (int k = 0; k < N; k++) c = c + CC_W'(v[k]);
      return c;
   endfunction

   // counts coincidences even when saturation held the weight
   always_ff @(posedge clk) begin
      if (rst)
         coinc_cnt <= '0;
      else if (state_q == IDLE && start)
         coinc_cnt <= '0;
      else if (accept_p0)
         coinc_cnt <= coinc_cnt + popcnt_x(x_pulse) * popcnt_d(d_pulse);
   end
`endif

endmodule

// File: tb/tb_coincidence_weight_updater.sv
// Table-driven bench for coincidence_weight_updater with a per-run expected-result scoreboard.
module tb_coincidence_weight_updater;
   localparam int M = 2, N = 2, BL = 10, W = 10;

   logic clk = 1'b0;
   logic rst, start, dir, init_en;
   logic signed [W-1:0] init_val;
   logic pulse_valid, pulse_ready, pulse_last, busy, done;
   logic [M-1:0] x_pulse;
   logic [N-1:0] d_pulse;
   logic [$clog2(BL+1)-1:0] beat_cnt;
   logic [M*N*W-1:0] wt_flat;
`ifdef COINC_STATS_EN
   logic [$clog2(BL*M*N+1)-1:0] coinc_cnt;
`endif

   coincidence_weight_updater #(.M(M), .N(N), .BL(BL), .W_BITS(W), .DG(25), .WMAX(255), .WMIN(-255)) dut (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .init_en(init_en), .init_val(init_val),
      .pulse_valid(pulse_valid), .pulse_ready(pulse_ready), .x_pulse(x_pulse), .d_pulse(d_pulse),
      .pulse_last(pulse_last), .busy(busy), .done(done), .beat_cnt(beat_cnt), .wt_flat(wt_flat)
`ifdef COINC_STATS_EN
      , .coinc_cnt(coinc_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ie; int iv; logic dir; logic [1:0] x; logic [1:0] d;
      int nb; logic last; logic gaps;
      int w00; int w01; int w10; int w11; int bc; int cc;
   } vec_t;

   vec_t tbl [11];
   vec_t exp_q [$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int getw(input int i, input int j);
      logic signed [W-1:0] t;
      t = wt_flat[(i*N+j)*W +: W];
      return int'(t);
   endfunction

   function automatic vec_t mk(input logic ie, input int iv, input logic dr, input logic [1:0] x,
                               input logic [1:0] d, input int nb, input logic last, input logic gaps,
                               input int w00, input int w01, input int w10, input int w11,
                               input int bc, input int cc);
      vec_t v;
      v.ie = ie; v.iv = iv; v.dir = dr; v.x = x; v.d = d; v.nb = nb; v.last = last; v.gaps = gaps;
      v.w00 = w00; v.w01 = w01; v.w10 = w10; v.w11 = w11; v.bc = bc; v.cc = cc;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      vec_t e;
      int acc, cyc, lim;
      bit gap;
      lim = (v.nb < BL) ? v.nb : BL;
      @(negedge clk);
      init_en = v.ie; init_val = W'(v.iv); dir = v.dir; start = 1'b1;
      exp_q.push_back(v);
      @(negedge clk);
      start = 1'b0; init_en = 1'b0; dir = 1'b0;
      chk("busy_in_run", int'(busy), 1);
      acc = 0; cyc = 0;
      while (acc < v.nb && cyc < 300) begin
         gap = v.gaps && ($urandom_range(0, 2) == 0);
         pulse_valid = !gap; x_pulse = v.x; d_pulse = v.d;
         pulse_last = v.last && (acc == v.nb - 1);
         if (!pulse_ready) break;
         @(posedge clk);
         if (!gap) acc++;
         @(negedge clk);
         cyc++;
         if (acc < lim) chk("no_early_done", int'(done), 0);
      end
      if (cyc >= 300) chk("run_timeout", cyc, 0);
      chk("beats_accepted", acc, lim);
      chk("done_pulse", int'(done), 1);
      chk("ready_in_finish", int'(pulse_ready), 0);
      e = exp_q.pop_front();
      chk("w00", getw(0, 0), e.w00);
      chk("w01", getw(0, 1), e.w01);
      chk("w10", getw(1, 0), e.w10);
      chk("w11", getw(1, 1), e.w11);
      chk("beat_cnt", int'(beat_cnt), e.bc);
`ifdef COINC_STATS_EN
      chk("coinc_cnt", int'(coinc_cnt), e.cc);
`endif
      // extra beat is still held valid across the FINISH edge
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("busy_idle", int'(busy), 0);
      chk("beat_cnt_hold", int'(beat_cnt), e.bc);
      chk("w11_hold", getw(1, 1), e.w11);
      pulse_valid = 1'b0; pulse_last = 1'b0; x_pulse = '0; d_pulse = '0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dir = 1'b0; init_en = 1'b0; init_val = '0;
      pulse_valid = 1'b0; x_pulse = '0; d_pulse = '0; pulse_last = 1'b0;

      //              ie  iv    dir  x      d      nb  last gaps w00   w01   w10   w11  bc  cc
      tbl[0]  = mk(1,   0,   0, 2'b11, 2'b11,  3, 1, 0,   75,   75,   75,   75,  3, 12);
      tbl[1]  = mk(1,   0,   0, 2'b01, 2'b10,  1, 1, 0,    0,   25,    0,    0,  1,  1);
      tbl[2]  = mk(0,   0,   1, 2'b01, 2'b10,  1, 1, 0,    0,    0,    0,    0,  1,  1);
      tbl[3]  = mk(1,  250,  0, 2'b11, 2'b11,  1, 1, 0,  255,  255,  255,  255,  1,  4);
      tbl[4]  = mk(1, -250,  1, 2'b11, 2'b11,  1, 1, 0, -255, -255, -255, -255,  1,  4);
      tbl[5]  = mk(1,  300,  1, 2'b00, 2'b11,  1, 1, 0,  255,  255,  255,  255,  1,  0);
      tbl[6]  = mk(1,   0,   0, 2'b11, 2'b11, 12, 0, 0,  250,  250,  250,  250, 10, 40);
      tbl[7]  = mk(1,   0,   0, 2'b11, 2'b11, 12, 0, 1,  250,  250,  250,  250, 10, 40);
      tbl[8]  = mk(1,   0,   0, 2'b11, 2'b01,  3, 1, 1,   75,    0,   75,    0,  3,  6);
      tbl[9]  = mk(1,  200,  0, 2'b11, 2'b11,  3, 1, 0,  255,  255,  255,  255,  3, 12);
      tbl[10] = mk(1,   0,   1, 2'b10, 2'b11, 10, 0, 0,    0,    0, -250, -250, 10, 20);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_wt_flat_zero", int'(wt_flat == '0), 1);
      chk("rst_ready", int'(pulse_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_beat_cnt", int'(beat_cnt), 0);
`ifdef COINC_STATS_EN
      chk("rst_coinc_cnt", int'(coinc_cnt), 0);
`endif

      for (int k = 0; k < 11; k++) run_vec(tbl[k]);
      chk("scoreboard_empty", exp_q.size(), 0);

      // reset in the middle of a run
      @(negedge clk);
      init_en = 1'b1; init_val = '0; start = 1'b1; dir = 1'b0;
      @(negedge clk);
      start = 1'b0; init_en = 1'b0;
      pulse_valid = 1'b1; x_pulse = 2'b11; d_pulse = 2'b11; pulse_last = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("mid_run_w00", getw(0, 0), 50);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(pulse_ready), 0);
      chk("abort_wt_zero", int'(wt_flat == '0), 1);
      chk("abort_beat_cnt", int'(beat_cnt), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_done", int'(done), 0);
      end
      pulse_valid = 1'b0;
      chk("abort_idle_wt", int'(wt_flat == '0), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
